simd_sat_addsub: RTL and testbench

- Pipelined, parametrised packed-SIMD add/subtract unit with per-lane two's-complement saturation.
- Generalises the fixed 16-bit/4-lane parallel sub-word adder: configurable width and lane size, add or subtract per operation, saturate or wrap per operation, and valid/ready flow control.
- Sits in the EX stage beside the ALU. It also serves as a standalone throughput engine for vector-style ops.

---
 rtl/simd_sat_addsub_pkg.sv | 29 ++
 rtl/simd_lane_addsub.sv | 33 +++
 rtl/simd_sat_addsub.sv | 148 ++++++++++++++
 tb/tb_simd_sat_addsub.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_sat_addsub_pkg.sv
// Shared types and helpers for the packed-SIMD saturating add/subtract unit.
// Lane saturation constants are produced at full MAX_LANE_W width and truncated by the user.
package simd_sat_addsub_pkg;

  localparam int MAX_LANE_W = 64;

  typedef struct packed {
    logic sub;
    logic sat;
  } op_ctrl_t;

  function automatic logic [MAX_LANE_W-1:0] lane_sat_max(input int unsigned lane_w);
    return (64'd1 << (lane_w - 1)) - 64'd1;
  endfunction

  function automatic logic [MAX_LANE_W-1:0] lane_sat_min(input int unsigned lane_w);
    return 64'd1 << (lane_w - 1);
  endfunction

  function automatic int unsigned calc_nlanes(input int unsigned data_w, input int unsigned lane_w);
    return data_w / lane_w;
  endfunction

  // Legal shapes: lanes at least 2 bits, no wider than the helper constants, and tiling DATA_W exactly.
  function automatic bit lane_cfg_ok(input int unsigned data_w, input int unsigned lane_w);
    return (lane_w >= 2) && (lane_w <= MAX_LANE_W) && (data_w >= lane_w) && ((data_w % lane_w) == 0);
  endfunction

endpackage

// File: rtl/simd_lane_addsub.sv
// One combinational lane: a + b' + cin with signed-overflow detection and optional saturation.
// The caller pre-inverts b and drives cin=1 for subtraction.
module simd_lane_addsub
  import simd_sat_addsub_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] bp,
  input  logic              cin,
  input  logic              sat,
  output logic [LANE_W-1:0] res,
  output logic              ovf
);

  localparam logic [LANE_W-1:0] SAT_MAX = LANE_W'(lane_sat_max(LANE_W));
  localparam logic [LANE_W-1:0] SAT_MIN = LANE_W'(lane_sat_min(LANE_W));

  logic [LANE_W-1:0] raw;

  assign raw = a + bp + {{(LANE_W-1){1'b0}}, cin};

  // Overflow only when both operands share a sign and the result sign differs from it.
  assign ovf = (a[LANE_W-1] == bp[LANE_W-1]) & (raw[LANE_W-1] != a[LANE_W-1]);

  always_comb begin
    res = raw;
    if (sat && ovf) begin
      res = a[LANE_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/simd_sat_addsub.sv
// Two-stage packed-SIMD add/subtract with per-lane saturation and valid/ready flow control.
// Optional saturation counter output enabled by defining SIMD_SAT_STATS_EN.
module simd_sat_addsub
  import simd_sat_addsub_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int LANE_W = 4,
  localparam int NLANES = calc_nlanes(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_sub,
  input  logic              in_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [NLANES-1:0] out_ovf,
  output logic              err_sticky,
  input  logic              err_clr
`ifdef SIMD_SAT_STATS_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  generate
    if (!lane_cfg_ok(DATA_W, LANE_W)) begin : g_cfg_err
      $error("simd_sat_addsub: DATA_W must be a multiple of LANE_W and LANE_W must be >= 2");
    end
  endgenerate

  logic              s1_valid;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_bp;
  op_ctrl_t          s1_ctrl;

  logic              s2_valid;
  logic              s2_en;
  logic              out_xfer;

  logic [DATA_W-1:0] lane_res;
  logic [NLANES-1:0] lane_ovf;

  // A stage may load when it is empty or its contents are moving on this cycle.
  assign s2_en     = ~s2_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_en;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid & out_ready;

  // S1 captures operands with B already inverted for subtraction; cin is the sub flag itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_bp    <= '0;
      s1_ctrl  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a         <= in_a;
        s1_bp        <= in_sub ? ~in_b : in_b;
        s1_ctrl.sub  <= in_sub;
        s1_ctrl.sat  <= in_sat;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      simd_lane_addsub #(
        .LANE_W(LANE_W)
      ) u_lane (
        .a   (s1_a[gi*LANE_W +: LANE_W]),
        .bp  (s1_bp[gi*LANE_W +: LANE_W]),
        .cin (s1_ctrl.sub),
        .sat (s1_ctrl.sat),
        .res (lane_res[gi*LANE_W +: LANE_W]),
        .ovf (lane_ovf[gi])
      );
    end
  endgenerate

  // S2 holds the result steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_sum  <= '0;
      out_ovf  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sum <= lane_res;
        out_ovf <= lane_ovf;
      end
    end
  end

  // A setting transfer outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
    end else if (out_xfer && (|out_ovf)) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef SIMD_SAT_STATS_EN
  logic        s2_sat;
  logic [16:0] sat_hits;
  logic [16:0] sat_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sat <= 1'b0;
    end else if (s2_en && s1_valid) begin
      s2_sat <= s1_ctrl.sat;
    end
  end

  always_comb begin
    sat_hits = '0;
    for (int i = 0; i < NLANES; i++) begin
      sat_hits = sat_hits + 17'(out_ovf[i] & s2_sat);
    end
  end

  assign sat_sum = {1'b0, sat_count} + sat_hits;

  // Clear wins over accumulation here; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (err_clr) begin
      sat_count <= '0;
    end else if (out_xfer) begin
      sat_count <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_simd_sat_addsub.sv
// Self-checking bench for simd_sat_addsub: directed cases plus randomized traffic against a lane-arithmetic model.
// Also checks sat_count when built with SIMD_SAT_STATS_EN.
module tb_simd_sat_addsub;

  localparam int DW   = 16;
  localparam int LW   = 4;
  localparam int NL   = DW / LW;
  localparam int LMAX = (1 << (LW - 1)) - 1;
  localparam int LMIN = -(1 << (LW - 1));

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          in_sub = 1'b0;
  logic          in_sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sum;
  logic [NL-1:0] out_ovf;
  logic          err_sticky;
  logic          err_clr = 1'b0;
`ifdef SIMD_SAT_STATS_EN
  logic [15:0]   sat_count;
`endif

  always #5 clk = ~clk;

  simd_sat_addsub #(
    .DATA_W(DW),
    .LANE_W(LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sub     (in_sub),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_ovf    (out_ovf),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`ifdef SIMD_SAT_STATS_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  typedef struct {
    logic [DW-1:0] sum;
    logic [NL-1:0] ovf;
    logic          sat;
    int            acc;
  } exp_t;

  exp_t          expq[$];
  exp_t          monE;
  int            nChecks = 0;
  int            nPass = 0;
  int            cycle = 0;
  int            tick = 0;
  bit            randDrive = 0;
  bit            stallWin = 0;
  bit            sawStall = 0;
  bit            held = 0;
  logic [DW-1:0] heldSum;
  logic [NL-1:0] heldOvf;
  logic          mSticky = 1'b0;
  int            mSatCount = 0;
  bit            xfer;
  exp_t          pin;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference: plain signed integer arithmetic per lane, clamped or wrapped.
  function automatic exp_t modelOp(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic sub, input logic sat, input int acc);
    exp_t e;
    e.sum = '0;
    e.ovf = '0;
    e.sat = sat;
    e.acc = acc;
    for (int i = 0; i < NL; i++) begin
      int av;
      int bv;
      int r;
      av = int'(a[i*LW +: LW]);
      bv = int'(b[i*LW +: LW]);
      if (av > LMAX) av -= (1 << LW);
      if (bv > LMAX) bv -= (1 << LW);
      r = sub ? av - bv : av + bv;
      if (r > LMAX || r < LMIN) begin
        e.ovf[i] = 1'b1;
        if (sat) r = (r > LMAX) ? LMAX : LMIN;
      end
      e.sum[i*LW +: LW] = LW'(r);
    end
    return e;
  endfunction

  function automatic logic [DW-1:0] randOperand();
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NL; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*LW +: LW] = '0;
        1:       v[i*LW +: LW] = LW'(LMAX);
        2:       v[i*LW +: LW] = LW'(LMIN);
        3:       v[i*LW +: LW] = '1;
        default: v[i*LW +: LW] = LW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    tick++;
    if (randDrive) begin
      out_ready = ($urandom_range(0, 3) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
    end else if (stallWin) begin
      out_ready = !(tick >= 3 && tick <= 6);
    end
  endtask

  // Presents one op and holds it until the handshake completes; leaves in_valid high for chaining.
  task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub, input logic sat);
    bit acc;
    acc = 0;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_sat   = sat;
    in_valid = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      stepCycle();
    end
    if (!acc) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      mSticky   = 1'b0;
      mSatCount = 0;
      held      = 0;
    end else begin
      checkOutput("in_ready", 32'(in_ready), 32'((expq.size() < 2) || out_ready));
      if (!in_ready) sawStall = 1;
      if (expq.size() == 0) checkOutput("out_valid_idle", 32'(out_valid), 32'd0);
      if (held) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_sum", 32'(out_sum), 32'(heldSum));
        checkOutput("hold_ovf", 32'(out_ovf), 32'(heldOvf));
      end
      held    = out_valid && !out_ready;
      heldSum = out_sum;
      heldOvf = out_ovf;
      checkOutput("err_sticky", 32'(err_sticky), 32'(mSticky));
`ifdef SIMD_SAT_STATS_EN
      checkOutput("sat_count", 32'(sat_count), 32'(mSatCount));
`endif
      xfer = out_valid && out_ready && (expq.size() != 0);
      if (xfer) begin
        monE = expq.pop_front();
        checkOutput("out_sum", 32'(out_sum), 32'(monE.sum));
        checkOutput("out_ovf", 32'(out_ovf), 32'(monE.ovf));
        checkOutput("latency_min", 32'((cycle - monE.acc) >= 2), 32'd1);
      end
      if (xfer && monE.ovf != '0) mSticky = 1'b1;
      else if (err_clr) mSticky = 1'b0;
      if (err_clr) mSatCount = 0;
      else if (xfer) begin
        mSatCount = mSatCount + $countones(monE.ovf & {NL{monE.sat}});
        if (mSatCount > 65535) mSatCount = 65535;
      end
      if (in_valid && in_ready) expq.push_back(modelOp(in_a, in_b, in_sub, in_sat, cycle));
    end
    cycle++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pin = modelOp(16'h0000, 16'h0008, 1'b1, 1'b1, 0);
    checkOutput("model_pin_sum", 32'(pin.sum), 32'h0007);
    checkOutput("model_pin_ovf", 32'(pin.ovf), 32'b0001);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_out_ovf", 32'(out_ovf), 32'd0);
    checkOutput("rst_err_sticky", 32'(err_sticky), 32'd0);
`ifdef SIMD_SAT_STATS_EN
    checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    stepCycle();
    out_ready = 1'b1;

    // Add with saturation; result appears exactly two cycles after acceptance.
    applyStimulus(16'h7381, 16'h1281, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    checkOutput("t1_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_sum", 32'(out_sum), 32'h7582);
    checkOutput("t1_ovf", 32'(out_ovf), 32'b1010);
    stepCycle();

    err_clr = 1'b1;
    stepCycle();
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("t2_cleared", 32'(err_sticky), 32'd0);
    stepCycle();
    applyStimulus(16'h7381, 16'h1281, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_sum", 32'(out_sum), 32'h8502);
    checkOutput("t2_ovf", 32'(out_ovf), 32'b1010);
    stepCycle();
    @(negedge clk);
    checkOutput("t2_sticky", 32'(err_sticky), 32'd1);
    stepCycle();

    applyStimulus(16'h0583, 16'h8213, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3_sum", 32'(out_sum), 32'h7380);
    checkOutput("t3_ovf", 32'(out_ovf), 32'b1010);
    stepCycle();

    // Back-to-back burst with the consumer stalled for cycles 3-6.
    tick     = 0;
    sawStall = 0;
    stallWin = 1;
    for (int k = 0; k < 10; k++) applyStimulus(randOperand(), randOperand(), 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    stallWin = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && expq.size() != 0; t++) stepCycle();
    checkOutput("t4_drained", 32'(expq.size()), 32'd0);
    checkOutput("t4_inready_dropped", 32'(sawStall), 32'd1);

    // Clear coinciding with an overflowing transfer: the set wins, then the clear takes effect.
    err_clr = 1'b1;
    applyStimulus(16'h7381, 16'h1281, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    stepCycle();
    @(negedge clk);
    checkOutput("t5_valid", 32'(out_valid), 32'd1);
    checkOutput("t5_pre_clear", 32'(err_sticky), 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("t5_set_wins", 32'(err_sticky), 32'd1);
    stepCycle();
    @(negedge clk);
    checkOutput("t5_clear_alone", 32'(err_sticky), 32'd0);
    stepCycle();
    err_clr = 1'b0;

    randDrive = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        applyStimulus(randOperand(), randOperand(), 1'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
        stepCycle();
      end
    end
    randDrive = 0;
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && expq.size() != 0; t++) stepCycle();
    checkOutput("rand_drained", 32'(expq.size()), 32'd0);

    // Two ops in flight, then asynchronous reset.
    out_ready = 1'b0;
    applyStimulus(16'h7777, 16'h1111, 1'b0, 1'b1);
    applyStimulus(16'h0000, 16'h8888, 1'b1, 1'b1);
    in_valid = 1'b0;
    stepCycle();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_async_sum", 32'(out_sum), 32'd0);
`ifdef SIMD_SAT_STATS_EN
    checkOutput("t6_sat_count", 32'(sat_count), 32'd0);
`endif
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) stepCycle();
    @(negedge clk);
    checkOutput("t6_no_stale", 32'(out_valid), 32'd0);
    checkOutput("t6_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
